sd_cache_lines: RTL and testbench
=================================

# sd_cache_lines

Write-back, direct-mapped tag controller for the SD card path, holding `LINES` resident 512-byte blocks instead of one. It sits between the memory-mapped SD window and the SPI block engine. On hits it acknowledges reads and writes. On misses it writes back dirty victims and fills new blocks over SPI. Block data lives in an external RAM addressed by `{line, addr[8:0]}`; this block owns only tags, valid/dirty bits and sequencing.

## Interface
Parameters:
- `LINES`, 4: number of resident blocks; power of two, 1..64.
- `LINE_BITS`, 2: log2(`LINES`). With `LINES`=1 it is still 1, and the index is forced to 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `read`  in  1  read request from the memory window.
- `write`  in  1  write request from the memory window.
- `addr`  in  32  byte address. `addr[31:9]` is the SD block number; its low `LINE_BITS` bits are the line index.
- `flush`  in  1  single-cycle request to write back all dirty lines; see Configuration.
- `busy`  in  1  SPI engine busy.
- `read_spi`  out  1  one-cycle pulse: fill `block` into `line`.
- `write_spi`  out  1  one-cycle pulse: write back `line` to `block`.
- `write_ram`  out  1  one-cycle pulse: commit the requester's byte to the data RAM.
- `block`  out  23  SD block number for the current SPI operation, or the requested block otherwise.
- `line`  out  `LINE_BITS`  data RAM line select for the current operation.
- `ready`  out  1  one-cycle completion pulse.

## Operation
- Per-line state: `tag[22:0]`, `valid`, `dirty`.
- Reset: all `valid`=0 and `dirty`=0; state is IDLE; `read_spi`, `write_spi`, `write_ram` and `ready` are 0; `block`=0; `line`=0.
- States and transitions:
  - IDLE samples requests, except in a cycle where `ready`=1.
  - `read` has priority over `write`; `flush` has lowest priority.
  - Hit (`valid` and tag match):
    - A read goes to HIT_RD.
    - A write goes to HIT_WR.
  - Miss, victim clean or invalid: go to FILL and pulse `read_spi` with `block` = the requested block.
  - Miss, victim dirty and valid:
    - Go to WB and pulse `write_spi` with `block` = the victim tag.
    - When the write-back completes, go directly to FILL with a `read_spi` pulse. There is no return to IDLE between the two.
  - FILL completion: set `tag`, `valid`=1 and `dirty`=0, then go to HIT_RD or HIT_WR according to the latched request type.
  - HIT_RD: pulse `ready`, then return to IDLE.
  - HIT_WR: pulse `write_ram` and `ready` together, set `dirty`=1, then return to IDLE.
- SPI completion rule: after issuing a pulse, the block waits until `busy` has been seen high, then waits for `busy` low. Completion is the first cycle with `busy`=0 after that high.
- The request type and `addr[31:9]` are latched at acceptance. `addr` may change after acceptance.
- The requester must drop `read`/`write` in the cycle `ready` is high.
- `read` and `write` asserted together: the request is served as a read and no `write_ram` is generated. The requester must re-issue the write.
- `flush` arriving during a miss or hit sequence is lost; the requester must wait for an IDLE slot.
- Reset mid-operation: return to IDLE immediately, and all lines become invalid. Dirty data is discarded. The SPI engine shares `rst_n`.

## Timing
- Request seen in IDLE at cycle T.
- Hit: `ready` in T+2. On a write hit, `write_ram` is also in T+2.
- Clean miss:
  - `read_spi` in T+1.
  - `ready` 2 cycles after the `busy` fall.
- Dirty miss:
  - `write_spi` in T+1.
  - `read_spi` 1 cycle after the write-back `busy` fall.
  - `ready` 2 cycles after the fill `busy` fall.
- `block` and `line` stay stable from the pulse cycle until completion.
- Outputs are registered; there are no combinational paths from inputs to outputs except `block` and `line` in IDLE.

## Configuration
- `SD_CACHE_FLUSH_EN` defined:
  - A `flush` accepted in IDLE starts FLUSH_SCAN over lines 0..`LINES`-1.
  - Each line that is valid and dirty gets a `write_spi` pulse with that line's tag, then a wait for completion, then `dirty` is cleared.
  - After the last line, `ready` pulses once. An all-clean flush gives `ready` at T+`LINES`+1.
- `SD_CACHE_FLUSH_EN` undefined: `flush` is ignored, no scan logic is built, and dirty data leaves the cache only through eviction.

## Test plan
- Reset, then read `addr`=0x0000_0200 with `LINES`=4 -> `read_spi` pulse with `block`=1, `line`=1; after the `busy` pulse ends, `ready` 2 cycles later and line 1 is valid/clean.
- Repeat the read at 0x0000_0200 -> no SPI activity, `ready` at T+2.
- Write 0x0000_0204 -> `write_ram` and `ready` at T+2, line 1 dirty. Then read 0x0000_0A00 (block 5, line 1) -> `write_spi` with `block`=1, then `read_spi` with `block`=5 one cycle after the `busy` fall, then `ready`.
- `read` and `write` together at a hit address -> exactly one `ready` and no `write_ram`.
- Assert `rst_n` low while waiting on `busy` during a fill -> all outputs 0 immediately; a following read of the same block misses.
- With `SD_CACHE_FLUSH_EN`: dirty lines 0 and 3, then `flush` -> two `write_spi` pulses (lines 0, 3 in order), one `ready`, all `dirty`=0. Without the macro: `flush` -> no output activity.

Source files
------------

// File: rtl/sd_cache_lines.sv
// rtl/sd_cache_lines.sv - direct-mapped write-back tag controller for the SD block path
// Optional flush scan is built only when SD_CACHE_FLUSH_EN is defined.
module sd_cache_lines #(
   parameter int LINES     = 4,
   parameter int LINE_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 read,
   input  logic                 write,
   input  logic [31:0]          addr,
   input  logic                 flush,
   input  logic                 busy,
   output logic                 read_spi,
   output logic                 write_spi,
   output logic                 write_ram,
   output logic [22:0]          block,
   output logic [LINE_BITS-1:0] line,
   output logic                 ready
);
   typedef enum logic [2:0] {
      IDLE, WB, FILL, HIT_RD, HIT_WR, FLUSH_SCAN, FLUSH_WAIT
   } state_t;

   state_t               state, state_d;
   logic [22:0]          tag_mem [LINES];
   logic [LINES-1:0]     valid, dirty;
   logic [22:0]          block_q, lat_blk, req_blk, blk_d, victim_tag;
   logic [LINE_BITS-1:0] line_q, req_idx, line_d;
   logic                 req_wr, busy_seen, hit, victim_dirty, spi_done, accept_rw;
   logic                 rd_spi_d, wr_spi_d, wr_ram_d, ready_d;
   logic                 unused_bits;

   assign req_blk      = addr[31:9];
   assign req_idx      = (LINES == 1) ? '0 : addr[9 +: LINE_BITS];
   assign victim_tag   = tag_mem[req_idx];
   assign hit          = valid[req_idx] && (victim_tag == req_blk);
   assign victim_dirty = valid[req_idx] && dirty[req_idx];
   assign accept_rw    = (state == IDLE) && !ready && (read || write);
   // busy must have been seen high since the pulse before a low counts as completion
   assign spi_done     = busy_seen && !busy;

   assign block = accept_rw ? req_blk : block_q;
   assign line  = accept_rw ? req_idx : line_q;

`ifdef SD_CACHE_FLUSH_EN
   logic [LINE_BITS-1:0] scan_idx;
   logic                 scan_dirty, scan_last, accept_flush;
   assign scan_dirty   = valid[scan_idx] && dirty[scan_idx];
   assign scan_last    = (scan_idx == LINE_BITS'(LINES - 1));
   assign accept_flush = (state == IDLE) && !ready && !read && !write && flush;
   assign unused_bits  = ^addr[8:0];
`else
   assign unused_bits  = ^{addr[8:0], flush};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         read_spi  <= 1'b0;
         write_spi <= 1'b0;
         write_ram <= 1'b0;
         ready     <= 1'b0;
         block_q   <= '0;
         line_q    <= '0;
      end else begin
         state     <= state_d;
         read_spi  <= rd_spi_d;
         write_spi <= wr_spi_d;
         write_ram <= wr_ram_d;
         ready     <= ready_d;
         block_q   <= blk_d;
         line_q    <= line_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (accept_rw) begin
               if (hit)               state_d = read ? HIT_RD : HIT_WR;
               else if (victim_dirty) state_d = WB;
               else                   state_d = FILL;
            end
`ifdef SD_CACHE_FLUSH_EN
            else if (accept_flush)    state_d = FLUSH_SCAN;
`endif
         end
         WB:             if (spi_done) state_d = FILL;
         FILL:           if (spi_done) state_d = req_wr ? HIT_WR : HIT_RD;
         HIT_RD, HIT_WR: state_d = IDLE;
`ifdef SD_CACHE_FLUSH_EN
         FLUSH_SCAN: begin
            if (scan_dirty)     state_d = FLUSH_WAIT;
            else if (scan_last) state_d = IDLE;
         end
         FLUSH_WAIT:     if (spi_done) state_d = scan_last ? IDLE : FLUSH_SCAN;
`endif
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_spi_d = 1'b0;
      wr_spi_d = 1'b0;
      wr_ram_d = 1'b0;
      ready_d  = 1'b0;
      blk_d    = block_q;
      line_d   = line_q;
      case (state)
         IDLE: begin
            if (accept_rw) begin
               blk_d  = req_blk;
               line_d = req_idx;
               if (!hit) begin
                  if (victim_dirty) begin
                     wr_spi_d = 1'b1;
                     blk_d    = victim_tag;
                  end else begin
                     rd_spi_d = 1'b1;
                  end
               end
            end
         end
         WB: begin
            if (spi_done) begin
               rd_spi_d = 1'b1;
               blk_d    = lat_blk;
            end
         end
         HIT_RD: ready_d = 1'b1;
         HIT_WR: begin
            ready_d  = 1'b1;
            wr_ram_d = 1'b1;
         end
`ifdef SD_CACHE_FLUSH_EN
         FLUSH_SCAN: begin
            if (scan_dirty) begin
               wr_spi_d = 1'b1;
               blk_d    = tag_mem[scan_idx];
               line_d   = scan_idx;
            end else if (scan_last) begin
               ready_d  = 1'b1;
            end
         end
         FLUSH_WAIT: if (spi_done && scan_last) ready_d = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid     <= '0;
         dirty     <= '0;
         req_wr    <= 1'b0;
         lat_blk   <= '0;
         busy_seen <= 1'b0;
`ifdef SD_CACHE_FLUSH_EN
         scan_idx  <= '0;
`endif
      end else begin
         if (rd_spi_d || wr_spi_d) busy_seen <= 1'b0;
         else if (busy)            busy_seen <= 1'b1;
         if (accept_rw) begin
            req_wr  <= write && !read;
            lat_blk <= req_blk;
         end
         if (state == FILL && spi_done) begin
            valid[line_q] <= 1'b1;
            dirty[line_q] <= 1'b0;
         end
         if (state == HIT_WR) dirty[line_q] <= 1'b1;
`ifdef SD_CACHE_FLUSH_EN
         if (accept_flush) scan_idx <= '0;
         if ((state == FLUSH_SCAN && !scan_dirty) || (state == FLUSH_WAIT && spi_done))
            scan_idx <= scan_idx + 1'b1;
         if (state == FLUSH_WAIT && spi_done) dirty[scan_idx] <= 1'b0;
`endif
      end
   end

   // tags need no reset: valid gates every use
   always_ff @(posedge clk) begin
      if (state == FILL && spi_done) tag_mem[line_q] <= lat_blk;
   end
endmodule

// File: tb/tb_sd_cache_lines.sv
// tb/tb_sd_cache_lines.sv - scoreboard bench for sd_cache_lines with a random SPI engine model
module tb_sd_cache_lines;
   localparam int LINES     = 4;
   localparam int LINE_BITS = 2;

   logic                 clk = 1'b0, rst_n = 1'b0, read = 1'b0, write = 1'b0, flush = 1'b0;
   logic [31:0]          addr = '0;
   logic                 busy, busy_q = 1'b0;
   logic                 read_spi, write_spi, write_ram, ready;
   logic [22:0]          block;
   logic [LINE_BITS-1:0] line;

   int vectors = 0, errors = 0, cyc = 0, fall_cyc = 0;
   bit spi_active = 1'b0;

   // kind: 0 read_spi, 1 write_spi, 2 write_ram, 3 ready
   typedef struct {int kind; logic [22:0] blk; int ln; bit after_wb;} exp_t;
   exp_t        expq[$];
   logic [22:0] m_tag   [LINES];
   bit          m_valid [LINES];
   bit          m_dirty [LINES];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign busy = busy_q & rst_n;

   sd_cache_lines #(.LINES(LINES), .LINE_BITS(LINE_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
      .flush(flush), .busy(busy), .read_spi(read_spi), .write_spi(write_spi),
      .write_ram(write_ram), .block(block), .line(line), .ready(ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic void push_exp(input int kind, input logic [22:0] blk, input int ln, input bit awb);
      exp_t e;
      e.kind = kind; e.blk = blk; e.ln = ln; e.after_wb = awb;
      expq.push_back(e);
   endfunction

   task automatic mon_pop(input int kind);
      exp_t e;
      if (expq.size() == 0) begin
         vectors++;
         errors++;
         $display("FAIL unexpected_pulse: got kind %0d expected none at cycle %0d", kind, cyc);
         return;
      end
      e = expq.pop_front();
      check("pulse_kind", kind, e.kind);
      if (kind < 2) begin
         check("spi_block", block, e.blk);
         check("spi_line", line, e.ln);
      end
      if (kind == 2) check("ram_line", line, e.ln);
      if (kind == 0 && e.after_wb) check("fill_after_wb", cyc, fall_cyc + 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (write_spi) mon_pop(1);
            if (read_spi)  mon_pop(0);
            if (write_ram) mon_pop(2);
            if (ready)     mon_pop(3);
         end
      end
   end

   // SPI engine: random start delay, random busy length
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && (read_spi || write_spi)) begin
            spi_active = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            busy_q = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            busy_q = 1'b0;
            fall_cyc = cyc;
            spi_active = 1'b0;
         end
      end
   end

   task automatic wait_ready(output bit done);
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (ready) done = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a);
      int          idx, t;
      logic [22:0] b;
      bit          hit, wb, done;
      b   = a[31:9];
      idx = int'(b % LINES);
      hit = m_valid[idx] && m_tag[idx] == b;
      if (!hit) begin
         wb = m_valid[idx] && m_dirty[idx];
         if (wb) push_exp(1, m_tag[idx], idx, 1'b0);
         push_exp(0, b, idx, wb);
         m_tag[idx] = b; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
      end
      if (wr && !rd) begin
         push_exp(2, '0, idx, 1'b0);
         m_dirty[idx] = 1'b1;
      end
      push_exp(3, '0, 0, 1'b0);
      @(negedge clk);
      read = rd; write = wr; addr = a; t = cyc;
      @(negedge clk);
      addr = $urandom;
      wait_ready(done);
      check("ready_seen", done, 1);
      if (done) begin
         if (hit) check("hit_latency", cyc - t, 2);
         else     check("miss_latency", cyc - fall_cyc, 2);
      end
      read = 1'b0; write = 1'b0;
      @(negedge clk);
      check("queue_drained", expq.size(), 0);
      expq.delete();
   endtask

   task automatic do_flush();
      int t, n, act;
      bit done;
      n = 0; act = 0;
`ifdef SD_CACHE_FLUSH_EN
      for (int i = 0; i < LINES; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            push_exp(1, m_tag[i], i, 1'b0);
            m_dirty[i] = 1'b0;
            n++;
         end
      end
      push_exp(3, '0, 0, 1'b0);
`endif
      @(negedge clk);
      flush = 1'b1; t = cyc;
      @(negedge clk);
      flush = 1'b0;
`ifdef SD_CACHE_FLUSH_EN
      wait_ready(done);
      check("flush_ready_seen", done, 1);
      if (done && n == 0) check("flush_clean_latency", cyc - t, LINES + 1);
`else
      for (int i = 0; i < 10; i++) begin
         if (read_spi || write_spi || write_ram || ready) act++;
         @(negedge clk);
      end
      check("flush_ignored_activity", act, 0);
      done = 1'b1;
`endif
      @(negedge clk);
      check("flush_queue_drained", expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      bit          done;
      logic [31:0] a;
      bit          rd, wr;
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("reset_read_spi", read_spi, 0);
      check("reset_write_spi", write_spi, 0);
      check("reset_write_ram", write_ram, 0);
      check("reset_ready", ready, 0);
      check("reset_block", block, 0);
      check("reset_line", line, 0);
      rst_n = 1'b1;

      do_op(1'b1, 1'b0, 32'h0000_0200);
      do_op(1'b1, 1'b0, 32'h0000_0200);
      do_op(1'b0, 1'b1, 32'h0000_0204);
      do_op(1'b1, 1'b0, 32'h0000_0A00);
      do_op(1'b1, 1'b1, 32'h0000_0A00);

      // reset while a fill is waiting on busy
      push_exp(0, 23'd9, 1, 1'b0);
      @(negedge clk);
      read = 1'b1; addr = 32'h0000_1200;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (busy) done = 1'b1;
      end
      check("fill_busy_seen", done, 1);
      rst_n = 1'b0; read = 1'b0;
      #1;
      check("midreset_read_spi", read_spi, 0);
      check("midreset_write_spi", write_spi, 0);
      check("midreset_write_ram", write_ram, 0);
      check("midreset_ready", ready, 0);
      check("midreset_block", block, 0);
      check("midreset_line", line, 0);
      expq.delete();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      end
      for (int i = 0; i < 20 && spi_active; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b1, 1'b0, 32'h0000_1200);
      do_op(1'b1, 1'b0, 32'h0000_0A00);

      do_op(1'b0, 1'b1, 32'h0000_0800);
      do_op(1'b0, 1'b1, 32'h0000_0E00);
      do_flush();
      do_flush();

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_flush();
         end else begin
            a  = (32'($urandom_range(0, 11)) << 9) | 32'($urandom_range(0, 511));
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            do_op(rd, wr, a);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
